// File: rtl/gd_pkg.sv
// Shared widths, saturation bounds, FSM encoding and tolerance helpers for the descent controller.
// Purely declarative: no latency and no flow control of its own.
package gd_pkg;

    localparam int Q88_W  = 16;
    localparam int Q248_W = 32;

    localparam logic [Q88_W-1:0] SAT_MAX16 = 16'h7FFF;
    localparam logic [Q88_W-1:0] SAT_MIN16 = 16'h8000;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_LOAD = 4'd1;
    localparam logic [3:0] ST_REQ  = 4'd2;
    localparam logic [3:0] ST_WAIT = 4'd3;
    localparam logic [3:0] ST_CAPT = 4'd4;
    localparam logic [3:0] ST_REL  = 4'd5;
    localparam logic [3:0] ST_UPD  = 4'd6;
    localparam logic [3:0] ST_CHK  = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_CAPT = ST_CAPT,
        S_REL  = ST_REL,
        S_UPD  = ST_UPD,
        S_CHK  = ST_CHK,
        S_DONE = ST_DONE
    } gd_state_t;

    function automatic logic [Q248_W-1:0] abs32(input logic [Q248_W-1:0] v);
        return v[Q248_W-1] ? (~v + 32'd1) : v;
    endfunction

    // The most negative diff has no positive magnitude, so it never counts as converged.
    function automatic logic within_tol(input logic [Q248_W-1:0] v, input logic [Q248_W-1:0] tol);
        return (v != 32'h8000_0000) && (abs32(v) <= tol);
    endfunction

endpackage

// File: rtl/grad_descent_ctrl_if.sv
// Start/done handshake bundle between the descent controller (master) and the gradient stage (slave).
// Gradient stage holds done and its results until the controller drops start.
interface grad_descent_ctrl_if;
    import gd_pkg::*;

    logic              grad_start;
    logic [Q88_W-1:0]  a_cur;
    logic [Q88_W-1:0]  b_cur;
    logic [Q88_W-1:0]  c_cur;
    logic [Q88_W-1:0]  d_cur;
    logic              grad_done;
    logic [Q248_W-1:0] grad_value;
    logic [Q248_W-1:0] a_diff;
    logic [Q248_W-1:0] b_diff;
    logic [Q248_W-1:0] c_diff;
    logic [Q248_W-1:0] d_diff;
    logic              grad_ovf;

    modport master (
        output grad_start, a_cur, b_cur, c_cur, d_cur,
        input  grad_done, grad_value, a_diff, b_diff, c_diff, d_diff, grad_ovf
    );

    modport slave (
        input  grad_start, a_cur, b_cur, c_cur, d_cur,
        output grad_done, grad_value, a_diff, b_diff, c_diff, d_diff, grad_ovf
    );

endinterface

// File: rtl/gd_sat_sub16.sv
// Combinational Q8.8 minus Q24.8 with clamp to the signed 16-bit range; sat flags any clamp.
// Zero latency, no flow control.
module gd_sat_sub16
    import gd_pkg::*;
(
    input  logic [Q88_W-1:0]  cur,
    input  logic [Q248_W-1:0] diff,
    output logic [Q88_W-1:0]  res,
    output logic              sat
);

    logic signed [Q248_W:0] wide;

    assign wide = $signed({{(Q248_W + 1 - Q88_W){cur[Q88_W-1]}}, cur}) - $signed({diff[Q248_W-1], diff});

    always_comb begin
        res = wide[Q88_W-1:0];
        sat = 1'b0;
        if (wide > 33'sd32767) begin
            res = SAT_MAX16;
            sat = 1'b1;
        end else if (wide < -33'sd32768) begin
            res = SAT_MIN16;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/grad_descent_ctrl.sv
// Gradient-descent iteration controller: per iteration = gradient-stage latency + 4 cycles; waits on grad_done rise/fall.
// Optional GD_BEST_TRACK_EN keeps the lowest-value point and presents it in DONE.
module grad_descent_ctrl
    import gd_pkg::*;
#(
    parameter logic [15:0] MAX_ITER  = 16'd256,
    parameter logic [31:0] TOLERANCE = 32'h0000_0001,
    parameter int          ITER_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [Q88_W-1:0]    a_init,
    input  logic [Q88_W-1:0]    b_init,
    input  logic [Q88_W-1:0]    c_init,
    input  logic [Q88_W-1:0]    d_init,
    grad_descent_ctrl_if.master gbus,
    output logic [Q248_W-1:0]   value_out,
    output logic [ITER_W-1:0]   iter_count,
    output logic                done,
    output logic                converged,
    output logic                overflow
);

    localparam logic [15:0] MAX_EFF = (MAX_ITER == 16'd0) ? 16'd1 : MAX_ITER;

    gd_state_t         state, nxt;
    logic [Q88_W-1:0]  pt     [4];
    logic [Q248_W-1:0] dcap   [4];
    logic [Q88_W-1:0]  sub_res[4];
    logic [3:0]        sub_sat;
    logic [Q248_W-1:0] vcap;
    logic              all_tol;
    logic              iter_hit;

    for (genvar i = 0; i < 4; i++) begin : g_sub
        gd_sat_sub16 u_sub (
            .cur  (pt[i]),
            .diff (dcap[i]),
            .res  (sub_res[i]),
            .sat  (sub_sat[i])
        );
    end

    assign all_tol = within_tol(dcap[0], TOLERANCE) && within_tol(dcap[1], TOLERANCE)
                  && within_tol(dcap[2], TOLERANCE) && within_tol(dcap[3], TOLERANCE);

    // A saturated counter that can never reach MAX_EFF still terminates the run.
    assign iter_hit = (32'(iter_count) >= 32'(MAX_EFF)) || (&iter_count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pt         <= '{default: '0};
            dcap       <= '{default: '0};
            vcap       <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                S_LOAD: begin
                    pt         <= '{a_init, b_init, c_init, d_init};
                    iter_count <= '0;
                    converged  <= 1'b0;
                    overflow   <= 1'b0;
                end
                S_CAPT: begin
                    vcap <= gbus.grad_value;
                    dcap <= '{gbus.a_diff, gbus.b_diff, gbus.c_diff, gbus.d_diff};
                    if (gbus.grad_ovf) begin
                        overflow <= 1'b1;
                    end
                end
                S_UPD: begin
                    if (!(&iter_count)) begin
                        iter_count <= iter_count + ITER_W'(1);
                    end
                    if (all_tol) begin
                        converged <= 1'b1;
                    end else begin
                        pt <= sub_res;
                        if (|sub_sat) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt  = state;
        done = 1'b0;
        case (state)
            S_IDLE: if (start) nxt = S_LOAD;
            S_LOAD: nxt = S_REQ;
            S_REQ:  nxt = S_WAIT;
            S_WAIT: if (gbus.grad_done) nxt = S_CAPT;
            S_CAPT: nxt = gbus.grad_ovf ? S_DONE : S_REL;
            S_REL:  if (!gbus.grad_done) nxt = S_UPD;
            S_UPD:  nxt = S_CHK;
            S_CHK:  nxt = (converged || overflow || iter_hit) ? S_DONE : S_REQ;
            S_DONE: begin
                done = 1'b1;
                if (!start) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign gbus.grad_start = (state == S_REQ) || (state == S_WAIT);

`ifdef GD_BEST_TRACK_EN
    logic              have_best;
    logic [Q88_W-1:0]  best_pt [4];
    logic [Q248_W-1:0] best_v;
    logic              show_best;

    // Strictly-smaller comparison so ties keep the earlier point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_best <= 1'b0;
            best_pt   <= '{default: '0};
            best_v    <= '0;
        end else if (state == S_LOAD) begin
            have_best <= 1'b0;
        end else if (state == S_CAPT && !gbus.grad_ovf &&
                     (!have_best || ($signed(gbus.grad_value) < $signed(best_v)))) begin
            have_best <= 1'b1;
            best_pt   <= pt;
            best_v    <= gbus.grad_value;
        end
    end

    assign show_best  = (state == S_DONE) && have_best;
    assign gbus.a_cur = show_best ? best_pt[0] : pt[0];
    assign gbus.b_cur = show_best ? best_pt[1] : pt[1];
    assign gbus.c_cur = show_best ? best_pt[2] : pt[2];
    assign gbus.d_cur = show_best ? best_pt[3] : pt[3];
    assign value_out  = show_best ? best_v : vcap;
`else
    assign gbus.a_cur = pt[0];
    assign gbus.b_cur = pt[1];
    assign gbus.c_cur = pt[2];
    assign gbus.d_cur = pt[3];
    assign value_out  = vcap;
`endif

endmodule
